// File: rtl/dsp_mac_pkg.sv
// dsp_mac_pkg
// Shared definitions for the DSP multiply-accumulate sequencer:
//   - OPMODE encodings for the first term (Z=0) and later terms (Z=P)
//   - OPMODE bit index that selects post-adder subtraction
//   - sequencer FSM state type
//   - number of pipeline drain cycles after the last operand
// Ports: none (package).
package dsp_mac_pkg;

    localparam logic [7:0] OPM_FIRST    = 8'b0000_0001;  // X=M, Z=0
    localparam logic [7:0] OPM_ACC      = 8'b0000_1001;  // X=M, Z=P
    localparam int         OPM_SUB_BIT  = 7;
    localparam int         DRAIN_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_CAPT,
        ST_RESULT
    } state_t;

    function automatic logic [7:0] opmode_for(input logic first, input logic sub);
        logic [7:0] opm;
        opm = first ? OPM_FIRST : OPM_ACC;
        opm[OPM_SUB_BIT] = sub;
        return opm;
    endfunction

endpackage

// File: rtl/dsp_mac_sat.sv
// dsp_mac_sat
// Combinational reduction of the 48-bit DSP P output to the RES_W-bit result.
// Build option: DSP_MAC_SAT_EN
//   defined   -> signed saturation to [-2^(RES_W-1), 2^(RES_W-1)-1]
//   undefined -> plain truncation to P[RES_W-1:0] (wraps)
// Ports:
//   p    in  48     DSP P value (signed)
//   res  out RES_W  reduced signed result
module dsp_mac_sat
    import dsp_mac_pkg::*;
#(
    parameter int RES_W = 32
) (
    input  logic [47:0]      p,
    output logic [RES_W-1:0] res
);

`ifdef DSP_MAC_SAT_EN
    localparam logic signed [47:0] SAT_MAX = 48'sh7FFF_FFFF_FFFF >>> (48 - RES_W);
    localparam logic signed [47:0] SAT_MIN = ~SAT_MAX;

    always_comb begin
        res = p[RES_W-1:0];
        if ($signed(p) > SAT_MAX) begin
            res = SAT_MAX[RES_W-1:0];
        end else if ($signed(p) < SAT_MIN) begin
            res = SAT_MIN[RES_W-1:0];
        end
    end
`else
    // Upper P bits are intentionally dropped in wrap mode.
    logic unused_p_bits;
    assign unused_p_bits = ^p;
    assign res = p[RES_W-1:0];
`endif

endmodule

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer
// Sequences one DSP multiply/post-add slice through an N-term signed MAC.
// The DSP itself lives beside this block at the top level; every DSP clock
// enable (CEA/CEB/CEM/CEP/CEOPMODE) is driven from dsp_ce so the whole slice
// advances in lockstep and freezes intact while no operand is offered.
// Build option: DSP_MAC_SAT_EN (saturating result reduction, see dsp_mac_sat).
//
// State table:
//   ST_IDLE   | waiting for a command, cmd_ready=1
//   ST_RUN    | streaming operand pairs into the DSP, in_ready=1
//   ST_DRAIN  | flushing M and P pipeline registers (DRAIN_CYCLES cycles)
//   ST_CAPT   | registering the reduced P value into res_data
//   ST_RESULT | res_valid=1 until res_ready
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_len terms, cmd_sub negates
//   in_valid/in_ready     operand handshake; in_a, in_b signed 18-bit
//   res_valid/res_ready   result handshake; res_data signed RES_W-bit
//   dsp_a, dsp_b          DSP A/B inputs
//   dsp_opmode            DSP OPMODE input
//   dsp_ce                common DSP clock enable
//   dsp_p                 DSP P output
//   busy                  high whenever not idle
module dsp_mac_sequencer
    import dsp_mac_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int RES_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic             cmd_sub,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [17:0]      in_a,
    input  logic [17:0]      in_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [RES_W-1:0] res_data,
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_ce,
    input  logic [47:0]      dsp_p,
    output logic             busy
);

    localparam logic [1:0] DRAIN_LOAD = 2'(DRAIN_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] term_cnt;
    logic             sub_q;
    logic [1:0]       drain_cnt;
    logic             last_term;
    logic [RES_W-1:0] p_reduced;

    assign last_term = (term_cnt == len_q - CNT_W'(1));
    assign busy      = (state != ST_IDLE);

    dsp_mac_sat #(.RES_W(RES_W)) u_sat (
        .p   (dsp_p),
        .res (p_reduced)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        dsp_ce    = 1'b0;
        dsp_a     = '0;
        dsp_b     = '0;
        unique case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = (cmd_len == '0) ? ST_RESULT : ST_RUN;
                end
            end
            ST_RUN: begin
                in_ready = 1'b1;
                dsp_a    = in_a;
                dsp_b    = in_b;
                dsp_ce   = in_valid;
                if (in_valid && last_term) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                dsp_ce = 1'b1;
                if (drain_cnt == '0) begin
                    state_nxt = ST_CAPT;
                end
            end
            ST_CAPT: begin
                state_nxt = ST_RESULT;
            end
            ST_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The OPMODE register only moves when an operand is accepted, so during
    // drain it keeps the type of the final term that is still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= '0;
            sub_q      <= 1'b0;
            term_cnt   <= '0;
            drain_cnt  <= '0;
            dsp_opmode <= '0;
            res_data   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        len_q    <= cmd_len;
                        sub_q    <= cmd_sub;
                        term_cnt <= '0;
                        if (cmd_len == '0) begin
                            res_data <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (in_valid) begin
                        term_cnt   <= term_cnt + CNT_W'(1);
                        dsp_opmode <= opmode_for(term_cnt == '0, sub_q);
                        drain_cnt  <= DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt != '0) begin
                        drain_cnt <= drain_cnt - 2'd1;
                    end
                end
                ST_CAPT: begin
                    res_data <= p_reduced;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
